// File: rtl/sha256_msg_schedule_if.sv
// Stream interface for the SHA-256 message schedule block:
// one input word stream (message words) and one output stream (schedule words).
interface sha256_msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        out_last;
  logic        busy;

  // Producer/consumer side: supplies message words, accepts schedule words
  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_index, out_last, busy
  );

  // Schedule block side
  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_index, out_last, busy
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander: loads 16 message words, then emits
// W[0..ROUNDS-1] one per cycle using a 16-entry shift buffer.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  sha256_msg_schedule_if.slave bus
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] wbuf_q [16];
  logic [31:0] wbuf_d [16];
  logic [3:0]  ld_cnt_q, ld_cnt_d;
  logic [5:0]  t_cnt_q, t_cnt_d;

  logic [31:0] shift_src [15];
  logic [31:0] w_new;
  logic        in_ready;
  logic        out_valid;
  logic        in_accept;
  logic        out_accept;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Lower 15 entries of the buffer after a left shift
  for (genvar gi = 0; gi < 15; gi++) begin : g_shift
    assign shift_src[gi] = wbuf_q[gi + 1];
  end

  // New schedule word W[t+16] from the current window W[t..t+15]
  assign w_new = sigma1(wbuf_q[14]) + wbuf_q[9] + sigma0(wbuf_q[1]) + wbuf_q[0];

  // Handshake and output decode; everything is forced quiet while reset is high
  assign in_ready   = ~reset & (state_q == S_LOAD);
  assign out_valid  = ~reset & (state_q == S_EMIT);
  assign in_accept  = bus.in_valid & in_ready;
  assign out_accept = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = out_valid ? wbuf_q[0] : 32'd0;
  assign bus.out_index = out_valid ? t_cnt_q : 6'd0;
  assign bus.out_last  = out_valid & (t_cnt_q == LAST_T);
  assign bus.busy      = ~reset & ((ld_cnt_q != 4'd0) | (state_q == S_EMIT));

  // Next-state logic: load shifts in message words, emit shifts in expanded words
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    t_cnt_d  = t_cnt_q;
    for (int i = 0; i < 16; i++) begin
      wbuf_d[i] = wbuf_q[i];
    end

    case (state_q)
      S_LOAD: begin
        if (in_accept) begin
          for (int i = 0; i < 15; i++) begin
            wbuf_d[i] = shift_src[i];
          end
          wbuf_d[15] = bus.in_word;
          if (ld_cnt_q == 4'd15) begin
            state_d  = S_EMIT;
            ld_cnt_d = 4'd0;
            t_cnt_d  = 6'd0;
          end else begin
            ld_cnt_d = ld_cnt_q + 4'd1;
          end
        end
      end
      S_EMIT: begin
        if (out_accept) begin
          for (int i = 0; i < 15; i++) begin
            wbuf_d[i] = shift_src[i];
          end
          wbuf_d[15] = w_new;
          if (t_cnt_q == LAST_T) begin
            state_d = S_LOAD;
            t_cnt_d = 6'd0;
          end else begin
            t_cnt_d = t_cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State registers with synchronous reset discarding any partial block
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_LOAD;
      ld_cnt_q <= 4'd0;
      t_cnt_q  <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        wbuf_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      t_cnt_q  <= t_cnt_d;
      for (int i = 0; i < 16; i++) begin
        wbuf_q[i] <= wbuf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a FIPS 180-4 style
// schedule model computed directly from the recurrence.
module tb_sha256_msg_schedule;

  localparam int ROUNDS = 64;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  sha256_msg_schedule_if bus ();

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  // Reference: W[t] = M[t] for t<16, else s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  function automatic sched_t model(input blk_t m);
    sched_t w;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        w[t] = m[t];
      end else begin
        w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
             + w[t-7]
             + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
             + w[t-16];
      end
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Feed 16 words with 'gap' idle cycles before each; checks first out_valid timing
  task automatic send_block(input blk_t m, input int gap);
    int n;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'($urandom_range(0, 1));
        if (i > 0) check("gap_busy", 32'(bus.busy), 32'd1);
        check("gap_out_valid", 32'(bus.out_valid), 32'd0);
        step();
      end
      bus.in_valid  = 1'b1;
      bus.in_word   = m[i];
      bus.out_ready = 1'($urandom_range(0, 1));
      n = 0;
      while (!bus.in_ready && n < 200) begin
        step();
        n++;
      end
      if (n >= 200) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      check("load_out_valid", 32'(bus.out_valid), 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("first_out_valid", 32'(bus.out_valid), 32'd1);
    check("first_index", 32'(bus.out_index), 32'd0);
  endtask

  // Collect schedule words up to stop_at, optionally with random backpressure
  task automatic recv_block(input sched_t exp, input bit stall, input int stop_at,
                            output sched_t got);
    int  k;
    int  cyc;
    logic rdy;
    k   = 0;
    cyc = 0;
    for (int i = 0; i < 64; i++) got[i] = 32'd0;
    while (k < stop_at && cyc < 3000) begin
      rdy           = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      bus.in_valid  = (k < ROUNDS - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_word   = $urandom;
      check("emit_in_ready", 32'(bus.in_ready), 32'd0);
      check("emit_out_valid", 32'(bus.out_valid), 32'd1);
      check("out_word", bus.out_word, exp[k]);
      check("out_index", 32'(bus.out_index), 32'(k));
      check("out_last", 32'(bus.out_last), 32'(k == ROUNDS - 1));
      if (rdy) begin
        got[k] = bus.out_word;
        k++;
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (cyc >= 3000) check("recv_timeout", 32'(k), 32'(stop_at));
    if (stop_at == ROUNDS) begin
      check("word_count", 32'(k), 32'(ROUNDS));
      check("post_out_valid", 32'(bus.out_valid), 32'd0);
      check("post_in_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    blk_t   abc;
    blk_t   zero;
    blk_t   rnd;
    sched_t exp;
    sched_t got;
    sched_t exp_abc;
    sched_t got_ref;

    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'd0;
      zero[i] = 32'd0;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    exp_abc = model(abc);

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_word   = 32'd0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_word", bus.out_word, 32'd0);
    check("rst_out_index", 32'(bus.out_index), 32'd0);
    reset = 1'b0;
    step();
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // "abc" block, no backpressure
    send_block(abc, 0);
    recv_block(exp_abc, 1'b0, ROUNDS, got);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);
    for (int i = 0; i < 16; i++) check("abc_echo", got[i], abc[i]);
    got_ref = got;
    $display("[TB] abc block done");

    // All-zero block
    send_block(zero, 0);
    exp = model(zero);
    recv_block(exp, 1'b0, ROUNDS, got);
    $display("[TB] zero block done");

    // "abc" block with random backpressure, must equal unstalled run
    send_block(abc, 0);
    recv_block(exp_abc, 1'b1, ROUNDS, got);
    for (int i = 0; i < ROUNDS; i++) check("stall_vs_ref", got[i], got_ref[i] ^ exp_abc[i] ^ exp_abc[i]);
    $display("[TB] backpressure block done");

    // Random block with 3 idle cycles before every word
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    send_block(rnd, 3);
    exp = model(rnd);
    recv_block(exp, 1'b0, ROUNDS, got);
    $display("[TB] gapped block done");

    // Reset while emitting t=30
    send_block(abc, 0);
    recv_block(exp_abc, 1'b0, 30, got);
    check("pre_rst_index", 32'(bus.out_index), 32'd30);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("midrst_out_valid2", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    step();
    check("after_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("after_rst_busy", 32'(bus.busy), 32'd0);
    send_block(abc, 0);
    recv_block(exp_abc, 1'b0, ROUNDS, got);
    check("after_rst_w16", got[16], 32'h61626380);
    $display("[TB] reset mid-emit done");

    // Back-to-back: random block then "abc" with no idle cycle between
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    send_block(rnd, 0);
    exp = model(rnd);
    recv_block(exp, 1'b1, ROUNDS, got);
    send_block(abc, 0);
    recv_block(exp_abc, 1'b0, ROUNDS, got);
    check("b2b_w16", got[16], 32'h61626380);
    $display("[TB] back-to-back done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
